// File: rtl/bcd_display_pkg.sv
// Shared definitions for the BCD seven-segment display converter:
// segment patterns, controller states and BCD register sizing.
package bcd_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_DIGIT [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  // ceil(data_w * log10(2)), with log10(2) taken as 0.30103
  function automatic int bcd_n_calc(input int data_w);
    return (data_w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_display_seg7_decoder.sv
// One BCD digit to an active-low seven-segment pattern (bit 7 = dp, left off).
module seg7_decoder
  import bcd_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd < 4'd10) seg = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/bcd_display.sv
// Binary to seven-segment converter: serial double-dabble, then sign,
// leading-zero blanking, decimal points and overflow handling.
//
// state    | meaning
// ST_IDLE  | ready for a request
// ST_SHIFT | one double-dabble step per cycle, DATA_W steps
// ST_DONE  | register the decoded display and pulse o_valid
module bcd_display
  import bcd_display_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIGITS = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_signed,
  input  logic                  i_blank,
  input  logic [DIGITS-1:0]     i_dp,
  output logic [8*DIGITS-1:0]   o_display,
  output logic                  o_valid,
  output logic                  o_overflow
);

  localparam int BCD_N = bcd_n_calc(DATA_W);
  localparam int ND    = (BCD_N > DIGITS) ? BCD_N : DIGITS;
  localparam int CNT_W = $clog2(DATA_W);

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     bin_q, mag;
  logic [4*BCD_N-1:0]    bcd_q;
  logic [4*BCD_N-2:0]    bcd_adj;
  logic [CNT_W-1:0]      cnt_q;
  logic                  neg_q, blank_q, is_neg, accept;
  logic [DIGITS-1:0]     dp_q;
  logic [3:0]            dig [ND];
  logic [7:0]            seg_raw [DIGITS];
  logic [7:0]            seg;
  logic [8*DIGITS-1:0]   disp_d;
  logic                  ovf_d;
  int                    msd, sign_pos;

  assign o_ready = (state_q == ST_IDLE);
  assign accept  = i_valid && o_ready;
  assign is_neg  = i_signed && i_data[DATA_W-1];
  // Low DATA_W bits of the (DATA_W+1)-bit negation; the most negative
  // input yields 2^(DATA_W-1), which still fits unsigned.
  assign mag     = is_neg ? (~i_data + 1'b1) : i_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The top digit never reaches 5 before a shift since the final value fits
  // in BCD_N digits, so it is passed through unadjusted and its bit 3 dropped.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < BCD_N - 1; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      else                         bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
    end
    bcd_adj[4*(BCD_N-1) +: 3] = bcd_q[4*(BCD_N-1) +: 3];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      blank_q    <= 1'b0;
      dp_q       <= '0;
      o_display  <= '1;
      o_overflow <= 1'b0;
      o_valid    <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state_q)
        ST_IDLE: if (accept) begin
          bin_q   <= mag;
          bcd_q   <= '0;
          cnt_q   <= CNT_W'(DATA_W - 1);
          neg_q   <= is_neg;
          blank_q <= i_blank;
          dp_q    <= i_dp;
        end
        ST_SHIFT: begin
          bcd_q <= {bcd_adj, bin_q[DATA_W-1]};
          bin_q <= {bin_q[DATA_W-2:0], 1'b0};
          cnt_q <= cnt_q - 1'b1;
        end
        ST_DONE: begin
          o_display  <= disp_d;
          o_overflow <= ovf_d;
          o_valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < ND; i++) dig[i] = 4'd0;
    for (int i = 0; i < BCD_N; i++) dig[i] = bcd_q[4*i +: 4];
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_dec
    seg7_decoder u_dec (.bcd(dig[k]), .seg(seg_raw[k]));
  end

  always_comb begin
    msd = 0;
    for (int i = 0; i < BCD_N; i++) if (dig[i] != 4'd0) msd = i;
    ovf_d = 1'b0;
    for (int i = DIGITS; i < BCD_N; i++) if (dig[i] != 4'd0) ovf_d = 1'b1;
    // Negative values need a free position above the leading digit.
    if (neg_q && msd >= DIGITS - 1) ovf_d = 1'b1;
    sign_pos = blank_q ? msd + 1 : DIGITS - 1;
    disp_d = '1;
    seg = SEG_BLANK;
    for (int k = 0; k < DIGITS; k++) begin
      seg = seg_raw[k];
      if (blank_q && k > msd)      seg = SEG_BLANK;
      if (neg_q && k == sign_pos)  seg = SEG_MINUS;
      if (ovf_d)                   seg = SEG_MINUS;
      seg[7] = seg[7] & ~dp_q[k];
      disp_d[8*k +: 8] = seg;
    end
  end

endmodule

// File: tb/tb_bcd_display.sv
// Scoreboard bench for bcd_display: reference model from decimal arithmetic,
// randomized requests, busy-time request hold and mid-conversion reset.
module tb_bcd_display;

  localparam int DATA_W = 32;
  localparam int DIGITS = 6;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_signed = 1'b0;
  logic        i_blank = 1'b0;
  logic [31:0] i_data = '0;
  logic [5:0]  i_dp = '0;
  logic        o_ready, o_valid, o_overflow;
  logic [47:0] o_display;

  bcd_display #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_signed(i_signed), .i_blank(i_blank), .i_dp(i_dp),
    .o_display(o_display), .o_valid(o_valid), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [47:0] disp;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, errors = 0, cyc = 0, accepts = 0, valids = 0;
  logic [47:0] last_disp;
  bit          mon_en = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic logic [7:0] seg_of(input int v);
    logic [7:0] tab [10];
    tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return tab[v];
  endfunction

  // Expected display from the decimal expansion of the value.
  function automatic void model(input logic [31:0] d, input logic sg, input logic bl,
                                input logic [5:0] dp, output logic [47:0] disp,
                                output logic ovf);
    longint     mag;
    int         dg[10];
    int         nd;
    bit         neg;
    logic [7:0] s;
    neg = sg && d[31];
    mag = neg ? (longint'(64'h1_0000_0000) - longint'({32'd0, d})) : longint'({32'd0, d});
    for (int i = 0; i < 10; i++) begin
      dg[i] = int'(mag % 10);
      mag   = mag / 10;
    end
    nd = 1;
    for (int i = 0; i < 10; i++) if (dg[i] != 0) nd = i + 1;
    ovf = (nd + (neg ? 1 : 0)) > DIGITS;
    disp = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (ovf)                                          s = 8'hBF;
      else if (k < nd)                                  s = seg_of(dg[k]);
      else if (neg && k == (bl ? nd : DIGITS - 1))      s = 8'hBF;
      else if (bl)                                      s = 8'hFF;
      else                                              s = seg_of(0);
      if (dp[k]) s[7] = 1'b0;
      disp[8*k +: 8] = s;
    end
  endfunction

  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst || !mon_en) begin
      last_disp = o_display;
    end else if (o_valid) begin
      valids++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid display=%h", o_display);
      end else begin
        e = sb.pop_front();
        checks += 3;
        if (o_display !== e.disp) begin
          errors++; $display("FAIL display got=%h exp=%h", o_display, e.disp);
        end
        if (o_overflow !== e.ovf) begin
          errors++; $display("FAIL overflow got=%b exp=%b", o_overflow, e.ovf);
        end
        if (cyc != e.cyc) begin
          errors++; $display("FAIL latency got_cycle=%0d exp_cycle=%0d", cyc, e.cyc);
        end
      end
      last_disp = o_display;
    end else begin
      checks++;
      if (o_display !== last_disp) begin
        errors++; $display("FAIL hold got=%h exp=%h", o_display, last_disp);
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic sg, input logic bl,
                      input logic [5:0] dp, input int junk);
    exp_t        e;
    logic [47:0] ed;
    logic        eo;
    int          w;
    @(negedge i_clk);
    w = 0;
    while (!o_ready && w < 200) begin
      @(negedge i_clk);
      w++;
    end
    if (!o_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout got=0 exp=1");
      return;
    end
    i_data = d; i_signed = sg; i_blank = bl; i_dp = dp; i_valid = 1'b1;
    model(d, sg, bl, dp, ed, eo);
    e.disp = ed; e.ovf = eo; e.cyc = cyc + 1 + DATA_W + 1;
    sb.push_back(e);
    accepts++;
    for (int j = 0; j < junk; j++) begin
      @(negedge i_clk);
      i_data = $urandom; i_signed = 1'($urandom); i_blank = 1'($urandom); i_dp = 6'($urandom);
    end
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((sb.size() != 0 || !o_ready) && w < 500) begin
      @(negedge i_clk);
      w++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
    end
    @(negedge i_clk);
  endtask

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin
    logic [31:0] d;
    repeat (3) @(negedge i_clk);
    #2 i_rst = 1'b0;
    @(negedge i_clk);
    check_val("reset_display", 64'(o_display), 64'hFFFF_FFFF_FFFF);
    check_val("reset_overflow", 64'(o_overflow), 64'd0);
    check_val("reset_valid", 64'(o_valid), 64'd0);
    check_val("reset_ready", 64'(o_ready), 64'd1);
    mon_en = 1;

    send(32'd123456, 1'b0, 1'b0, 6'b0, 0);
    wait_idle();
    check_val("lit_123456", 64'(o_display), 64'hF9A4_B099_9282);
    send(32'd0, 1'b0, 1'b1, 6'b000001, 0);
    wait_idle();
    check_val("lit_zero_dp", 64'(o_display), 64'hFFFF_FFFF_FF40);
    send(32'd1000000, 1'b0, 1'b0, 6'b0, 0);
    wait_idle();
    check_val("lit_ovf", 64'(o_overflow), 64'd1);
    send(32'd7, 1'b0, 1'b0, 6'b0, 0);
    wait_idle();
    check_val("lit_seven", 64'({o_overflow, o_display[7:0]}), 64'h0F8);
    send(32'hFFFF_FFD6, 1'b1, 1'b1, 6'b0, 0);
    wait_idle();
    check_val("lit_minus42", 64'(o_display), 64'hFFFF_FFBF_99A4);
    send(32'h8000_0000, 1'b1, 1'b1, 6'b0, 0);
    send(32'd999999, 1'b0, 1'b0, 6'b101010, 8);
    send(32'hFFFF_FFFF, 1'b1, 1'b0, 6'b111111, 0);
    send(32'hFFF8_5EE1, 1'b1, 1'b0, 6'b0, 0);
    send(32'hFFF8_5EE1, 1'b1, 1'b1, 6'b0, 0);

    for (int n = 0; n < 60; n++) begin
      case ($urandom % 4)
        0:       d = $urandom % 1000;
        1:       d = $urandom % 1000000;
        2:       d = $urandom;
        default: d = 32'(0) - ($urandom % 100000);
      endcase
      repeat ($urandom % 3) @(negedge i_clk);
      send(d, 1'($urandom), 1'($urandom), 6'($urandom),
           (($urandom % 3) == 0) ? int'($urandom % 11) : 0);
    end
    wait_idle();

    send(32'd999999, 1'b0, 1'b0, 6'b0, 0);
    repeat (9) @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    check_val("abort_display", 64'(o_display), 64'hFFFF_FFFF_FFFF);
    check_val("abort_ready", 64'(o_ready), 64'd1);
    check_val("abort_valid", 64'(o_valid), 64'd0);
    void'(sb.pop_back());
    accepts--;
    @(negedge i_clk);
    #2 i_rst = 1'b0;
    repeat (DATA_W + 10) @(negedge i_clk);
    check_val("abort_no_valid", 64'(valids), 64'(accepts));

    send(32'd42, 1'b0, 1'b1, 6'b0, 0);
    wait_idle();
    check_val("valid_count", 64'(valids), 64'(accepts));
    check_val("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bcd_display.md
BCD_DISPLAY -- requirements
Module: bcd_display

Interface
REQ-001 SHALL have parameter DATA_W, default 32, input binary width (range 4..32).
REQ-002 SHALL have parameter DIGITS, default 6, number of 7-segment digits driven (range 1..10).
REQ-003 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-004 i_clk  input  1  rising-edge clock.
REQ-005 i_rst  input  1  asynchronous, active-high reset.
REQ-006 i_valid  input  1  request a conversion of i_data.
REQ-007 o_ready  output  1  high when a request can be accepted.
REQ-008 i_data  input  DATA_W  value to display.
REQ-009 i_signed  input  1  treat i_data as two's complement.
REQ-010 i_blank  input  1  blank leading zeros.
REQ-011 i_dp  input  DIGITS  decimal point enable per digit, bit k = digit k.
REQ-012 o_display  output  8*DIGITS  segments, active-low, byte k = digit k (0 = units), bit 7 = dp.
REQ-013 o_valid  output  1  one-cycle pulse when o_display is updated.
REQ-014 o_overflow  output  1  last result did not fit in DIGITS.

Function
REQ-015 SHALL accept a request on the rising edge where i_valid and o_ready are both high, capturing i_data, i_signed, i_blank and i_dp.
REQ-016 SHALL use FSM IDLE -> SHIFT -> DONE -> IDLE; o_ready high only in IDLE; i_valid outside IDLE is ignored, not queued.
REQ-017 SHALL convert in SHIFT by double-dabble, one bit per cycle, exactly DATA_W cycles, on a BCD register of BCD_N = ceil(DATA_W*log10(2)) digits.
REQ-018 SHALL, in signed mode with i_data[DATA_W-1] set, convert the magnitude (two's-complement negation in DATA_W+1 bits, so the most negative value converts correctly).
REQ-019 SHALL in DONE update o_display and o_overflow and pulse o_valid for one cycle; o_valid occurs DATA_W+1 cycles after the accept edge; o_ready returns high the following cycle.
REQ-020 SHALL decode digits 0..9 as C0,F9,A4,B0,99,92,82,F8,80,90 (hex); blank = FF; minus = BF.
REQ-021 SHALL clear bit 7 of byte k when captured i_dp[k] is set, including on blanked digits.
REQ-022 SHALL, with blanking, blank every digit above the most significant non-zero digit; digit 0 always shows a numeral (value 0 shows "0").
REQ-023 SHALL place the minus sign in the digit immediately above the most significant non-zero digit when blanking, else in digit DIGITS-1.
REQ-024 SHALL flag overflow when any BCD digit at index >= DIGITS is non-zero, or, for negative values, when the sign position would exceed DIGITS-1.
REQ-025 SHALL, on overflow, drive every digit to minus (BF, dp still applied) and set o_overflow.
REQ-026 SHALL hold o_display and o_overflow between updates.

Reset
REQ-027 SHALL on i_rst, at any time including mid-SHIFT, abort the conversion and enter IDLE.
REQ-028 SHALL reset o_display to all FF, o_overflow to 0, o_valid to 0, o_ready to 1.

Structure
REQ-029 SHALL take segment constants (digit patterns, blank, minus), FSM state type and a BCD_N calculation function from shared package bcd_display_pkg.
REQ-030 SHALL instantiate sub-module seg7_decoder (4-bit BCD in, 8-bit active-low pattern out) once per digit.

Verification
REQ-031 DATA_W=32, DIGITS=6, unsigned 123456, no blank -> after 33 cycles o_display = 82,92,99,B0,A4,F9 (digit 0..5), o_valid pulse, o_overflow=0.
REQ-032 Unsigned 0, i_blank=1, i_dp=0b000001 -> digit 0 = 40, digits 1..5 = FF.
REQ-033 Unsigned 1000000 -> all digits BF, o_overflow=1; then 7 -> digit 0 = F8, o_overflow=0.
REQ-034 Signed 32'hFFFFFFD6 (-42), i_blank=1 -> digit 0 = A4, digit 1 = 99, digit 2 = BF, digits 3..5 = FF; signed 32'h80000000 -> overflow.
REQ-035 i_valid held high during SHIFT with new data -> ignored; exactly one o_valid per accepted request.
REQ-036 i_rst asserted at SHIFT cycle 10 -> o_display all FF, o_ready=1 immediately; no o_valid pulse from the aborted request.
